// File: rtl/lbist_ctrl.sv
// rtl/lbist_ctrl.sv - logic BIST sequencer: seed, run, flush, compare, report go/no-go
module lbist_ctrl #(
  parameter int               N_PATTERNS   = 1024,
  parameter int               INIT_CYCLES  = 4,
  parameter int               FLUSH_CYCLES = 3,
  parameter int               SIG_W        = 32,
  parameter logic [SIG_W-1:0] GOLDEN_SIG   = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [SIG_W-1:0] misr_sig_i,
  output logic             test_mode_o,
  output logic             core_rst_o,
  output logic             tpg_seed_load_o,
  output logic             tpg_en_o,
  output logic             misr_clear_o,
  output logic             misr_en_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             go_nogo_o
);

  // One shared counter sized for the longest phase; it only ever reaches LIMIT-1.
  localparam int CNT_MAX_IR = (N_PATTERNS > INIT_CYCLES) ? N_PATTERNS : INIT_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_IR > FLUSH_CYCLES) ? CNT_MAX_IR : FLUSH_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(N_PATTERNS - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = (FLUSH_CYCLES > 0) ? CNT_W'(FLUSH_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INIT    = 3'd1;
  localparam logic [2:0] ST_RUN     = 3'd2;
  localparam logic [2:0] ST_FLUSH   = 3'd3;
  localparam logic [2:0] ST_COMPARE = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  // With no flush phase the last pattern cycle hands straight over to the compare.
  localparam logic [2:0] ST_RUN_EXIT = (FLUSH_CYCLES > 0) ? ST_FLUSH : ST_COMPARE;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             go_nogo_q, go_nogo_d;
  logic             sig_match;

  assign sig_match = (misr_sig_i == GOLDEN_SIG);

  // Next-state, phase counter and pass-flag decisions; dropping start in any active phase aborts.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    go_nogo_d = go_nogo_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d   = ST_INIT;
          cnt_d     = '0;
          go_nogo_d = 1'b0;
        end
      end
      ST_INIT: begin
        if (!start_i) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          go_nogo_d = 1'b0;
        end else if (cnt_q == INIT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
        if (!start_i) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          go_nogo_d = 1'b0;
        end else if (cnt_q == RUN_LAST) begin
          state_d = ST_RUN_EXIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_FLUSH: begin
        if (!start_i) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          go_nogo_d = 1'b0;
        end else if (cnt_q == FLUSH_LAST) begin
          state_d = ST_COMPARE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_COMPARE: begin
        cnt_d = '0;
        if (!start_i) begin
          state_d   = ST_IDLE;
          go_nogo_d = 1'b0;
        end else begin
          state_d   = ST_DONE;
          go_nogo_d = sig_match;
        end
      end
      ST_DONE: begin
        // The verdict survives the return to IDLE so software can read it after releasing start.
        cnt_d = '0;
        if (!start_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        go_nogo_d = 1'b0;
      end
    endcase
  end

  // State, counter and pass flag registers; reset wins over any phase.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      go_nogo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      go_nogo_q <= go_nogo_d;
    end
  end

  // Every control output is a pure decode of the registered state, so none can glitch.
  assign test_mode_o     = (state_q == ST_INIT) || (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign core_rst_o      = (state_q == ST_INIT);
  assign tpg_seed_load_o = (state_q == ST_INIT);
  assign misr_clear_o    = (state_q == ST_INIT);
  assign tpg_en_o        = (state_q == ST_RUN);
  assign misr_en_o       = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign busy_o          = (state_q == ST_INIT) || (state_q == ST_RUN) ||
                           (state_q == ST_FLUSH) || (state_q == ST_COMPARE);
  assign done_o          = (state_q == ST_DONE);
  assign go_nogo_o       = go_nogo_q;

endmodule

// File: tb/tb_lbist_ctrl.sv
// tb/tb_lbist_ctrl.sv - directed bench for lbist_ctrl
module tb_lbist_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic [31:0] sig_a, sig_b;

  logic test_mode_a, core_rst_a, seed_a, tpg_en_a, clr_a, misr_en_a, busy_a, done_a, go_a;
  logic test_mode_b, core_rst_b, seed_b, tpg_en_b, clr_b, misr_en_b, busy_b, done_b, go_b;
  logic [8:0] outs_a, outs_b;

  int total = 0;
  int bad   = 0;
  int n_core, n_seed, n_clr, n_tpg, n_misr, n_tmode, n_busy, n_done, excl_err;

  always #5 clk = ~clk;

  assign outs_a = {test_mode_a, core_rst_a, seed_a, tpg_en_a, clr_a, misr_en_a, busy_a, done_a, go_a};
  assign outs_b = {test_mode_b, core_rst_b, seed_b, tpg_en_b, clr_b, misr_en_b, busy_b, done_b, go_b};

  lbist_ctrl #(
    .N_PATTERNS(16), .INIT_CYCLES(4), .FLUSH_CYCLES(2), .SIG_W(32), .GOLDEN_SIG(32'hA5A50001)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .misr_sig_i(sig_a),
    .test_mode_o(test_mode_a), .core_rst_o(core_rst_a), .tpg_seed_load_o(seed_a),
    .tpg_en_o(tpg_en_a), .misr_clear_o(clr_a), .misr_en_o(misr_en_a),
    .busy_o(busy_a), .done_o(done_a), .go_nogo_o(go_a)
  );

  lbist_ctrl #(
    .N_PATTERNS(16), .INIT_CYCLES(4), .FLUSH_CYCLES(0), .SIG_W(32), .GOLDEN_SIG(32'hA5A50001)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .misr_sig_i(sig_b),
    .test_mode_o(test_mode_b), .core_rst_o(core_rst_b), .tpg_seed_load_o(seed_b),
    .tpg_en_o(tpg_en_b), .misr_clear_o(clr_b), .misr_en_o(misr_en_b),
    .busy_o(busy_b), .done_o(done_b), .go_nogo_o(go_b)
  );

  task automatic clear_counts();
    n_core = 0; n_seed = 0; n_clr = 0; n_tpg = 0; n_misr = 0;
    n_tmode = 0; n_busy = 0; n_done = 0; excl_err = 0;
  endtask

  // One clock, then sample the selected DUT away from the edge and tally its outputs.
  task automatic step(input bit use_b);
    logic [8:0] o;
    @(posedge clk);
    #1;
    o = use_b ? outs_b : outs_a;
    if (o[8]) n_tmode++;
    if (o[7]) n_core++;
    if (o[6]) n_seed++;
    if (o[5]) n_tpg++;
    if (o[4]) n_clr++;
    if (o[3]) n_misr++;
    if (o[2]) n_busy++;
    if (o[1]) n_done++;
    if ((int'(o[7]) + int'(o[5]) + int'(o[3] && !o[5])) > 1) excl_err++;
  endtask

  task automatic run_to_done(input bit use_b, output int lat);
    lat = 0;
    while (!(use_b ? done_b : done_a) && lat < 200) begin
      step(use_b);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; sig_a = '0; sig_b = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (outs_a !== 9'd0) begin bad++; $display("FAIL reset_a: got %b want %b", outs_a, 9'd0); end
    total++;
    if (outs_b !== 9'd0) begin bad++; $display("FAIL reset_b: got %b want %b", outs_b, 9'd0); end
    rst = 1'b0;
    step(1'b0);
  endtask

  task automatic test_pass_run();
    int lat;
    clear_counts();
    start_a = 1'b1; sig_a = 32'hA5A50001;
    run_to_done(1'b0, lat);
    total++; if (lat !== 24) begin bad++; $display("FAIL pass_latency: got %0d want 24", lat); end
    total++; if (go_a !== 1'b1) begin bad++; $display("FAIL pass_go: got %b want 1", go_a); end
    total++; if (n_core !== 4) begin bad++; $display("FAIL pass_core_rst: got %0d want 4", n_core); end
    total++; if (n_seed !== 4) begin bad++; $display("FAIL pass_seed: got %0d want 4", n_seed); end
    total++; if (n_clr !== 4) begin bad++; $display("FAIL pass_misr_clr: got %0d want 4", n_clr); end
    total++; if (n_tpg !== 16) begin bad++; $display("FAIL pass_tpg_en: got %0d want 16", n_tpg); end
    total++; if (n_misr !== 18) begin bad++; $display("FAIL pass_misr_en: got %0d want 18", n_misr); end
    total++; if (n_tmode !== 22) begin bad++; $display("FAIL pass_test_mode: got %0d want 22", n_tmode); end
    total++; if (n_busy !== 23) begin bad++; $display("FAIL pass_busy: got %0d want 23", n_busy); end
    total++; if (excl_err !== 0) begin bad++; $display("FAIL pass_exclusive: got %0d want 0", excl_err); end
    repeat (3) step(1'b0);
    total++;
    if ({done_a, busy_a} !== 2'b10) begin bad++; $display("FAIL done_hold: got %b want 10", {done_a, busy_a}); end
    start_a = 1'b0;
    step(1'b0);
    total++;
    if (outs_a !== 9'b000000001) begin bad++; $display("FAIL release_keep_go: got %b want %b", outs_a, 9'b000000001); end
    step(1'b0);
    total++; if (go_a !== 1'b1) begin bad++; $display("FAIL idle_go_hold: got %b want 1", go_a); end
  endtask

  task automatic test_fail_run();
    int lat;
    clear_counts();
    start_a = 1'b1; sig_a = 32'hA5A50000;
    run_to_done(1'b0, lat);
    total++; if (lat !== 24) begin bad++; $display("FAIL fail_latency: got %0d want 24", lat); end
    total++; if ({done_a, go_a} !== 2'b10) begin bad++; $display("FAIL fail_go: got %b want 10", {done_a, go_a}); end
    start_a = 1'b0;
    step(1'b0);
  endtask

  task automatic test_abort();
    int guard;
    clear_counts();
    start_a = 1'b1; sig_a = 32'hA5A50001;
    guard = 0;
    while (n_tpg < 7 && guard < 100) begin
      step(1'b0);
      guard++;
    end
    start_a = 1'b0;
    step(1'b0);
    total++; if (outs_a !== 9'd0) begin bad++; $display("FAIL abort_outputs: got %b want %b", outs_a, 9'd0); end
    total++; if (n_tpg !== 7) begin bad++; $display("FAIL abort_tpg_count: got %0d want 7", n_tpg); end
    repeat (5) step(1'b0);
    total++; if (n_done !== 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", n_done); end
  endtask

  task automatic test_reset_in_flush();
    int guard;
    int lat;
    clear_counts();
    start_a = 1'b1; sig_a = 32'hA5A50001;
    guard = 0;
    while (!(misr_en_a && !tpg_en_a) && guard < 100) begin
      step(1'b0);
      guard++;
    end
    total++; if (n_tpg !== 16) begin bad++; $display("FAIL flush_reached: got %0d want 16", n_tpg); end
    rst = 1'b1; start_a = 1'b0;
    step(1'b0);
    rst = 1'b0;
    total++; if (outs_a !== 9'd0) begin bad++; $display("FAIL flush_reset: got %b want %b", outs_a, 9'd0); end
    step(1'b0);
    clear_counts();
    start_a = 1'b1;
    run_to_done(1'b0, lat);
    total++; if (lat !== 24) begin bad++; $display("FAIL rerun_latency: got %0d want 24", lat); end
    total++; if (go_a !== 1'b1) begin bad++; $display("FAIL rerun_go: got %b want 1", go_a); end
    start_a = 1'b0;
    step(1'b0);
  endtask

  task automatic test_no_flush();
    int lat;
    clear_counts();
    start_b = 1'b1; sig_b = 32'hA5A50001;
    run_to_done(1'b1, lat);
    total++; if (lat !== 22) begin bad++; $display("FAIL noflush_latency: got %0d want 22", lat); end
    total++; if (n_misr !== 16) begin bad++; $display("FAIL noflush_misr_en: got %0d want 16", n_misr); end
    total++; if (n_tpg !== 16) begin bad++; $display("FAIL noflush_tpg_en: got %0d want 16", n_tpg); end
    total++; if (n_busy !== 21) begin bad++; $display("FAIL noflush_busy: got %0d want 21", n_busy); end
    total++; if (go_b !== 1'b1) begin bad++; $display("FAIL noflush_go: got %b want 1", go_b); end
    start_b = 1'b0;
    step(1'b1);
  endtask

  task automatic test_back_to_back();
    int lat;
    clear_counts();
    start_a = 1'b1; sig_a = 32'hA5A50001;
    run_to_done(1'b0, lat);
    total++; if (go_a !== 1'b1) begin bad++; $display("FAIL b2b_first_go: got %b want 1", go_a); end
    start_a = 1'b0;
    step(1'b0);
    total++; if ({done_a, go_a} !== 2'b01) begin bad++; $display("FAIL b2b_idle: got %b want 01", {done_a, go_a}); end
    start_a = 1'b1; sig_a = 32'hA5A50000;
    step(1'b0);
    total++;
    if ({core_rst_a, go_a} !== 2'b10) begin bad++; $display("FAIL b2b_go_clear: got %b want 10", {core_rst_a, go_a}); end
    run_to_done(1'b0, lat);
    total++; if (lat !== 23) begin bad++; $display("FAIL b2b_latency: got %0d want 23", lat); end
    total++; if ({done_a, go_a} !== 2'b10) begin bad++; $display("FAIL b2b_final_go: got %b want 10", {done_a, go_a}); end
    start_a = 1'b0;
    step(1'b0);
  endtask

  initial begin
    test_reset();
    test_pass_run();
    test_fail_run();
    test_abort();
    test_reset_in_flush();
    test_no_flush();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
